// File: rtl/player_trail_gen_pkg.sv
// Shared definitions for the player trail generator and the VGA picture stage.
// Holds the gamemode encodings, sprite geometry and the trail FSM state type.
package player_trail_gen_pkg;

  typedef enum logic [1:0] {
    GM_START = 2'b00,
    GM_PLAY  = 2'b01,
    GM_PAUSE = 2'b10,
    GM_OVER  = 2'b11
  } gamemode_e;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_RUN   = 2'd1,
    ST_HOLD  = 2'd2
  } trail_state_e;

  localparam int PLAYER_X_DEF    = 160;
  localparam int PLAYER_SIZE_DEF = 40;
  localparam int TRAIL_SIZE_DEF  = 8;
  localparam int TRAIL_NUM_DEF   = 28;
  localparam int LIFE_MAX_DEF    = 10;

  localparam int X_W    = 10;
  localparam int Y_W    = 9;
  localparam int LIFE_W = 4;
  localparam int CNT_W  = 4;

  // Particle top edge centred on the player, clamped to the bottom of the y range.
  function automatic logic [Y_W-1:0] spawn_y(input logic [Y_W-1:0] py, input int unsigned off);
    logic [Y_W:0] sum;
    sum = {1'b0, py} + (Y_W+1)'(off);
    if (sum > (Y_W+1)'(511)) return 9'd511;
    else return sum[Y_W-1:0];
  endfunction

endpackage

// File: rtl/player_trail_gen_slot.sv
// One trail particle: position and remaining life, with spawn load and
// per-frame drift/decay.
module trail_slot
  import player_trail_gen_pkg::*;
#(
  parameter int LIFE_MAX = LIFE_MAX_DEF,
  parameter int DRIFT    = 4,
  parameter int SPAWN_X  = PLAYER_X_DEF - TRAIL_SIZE_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              step,
  input  logic              load,
  input  logic [Y_W-1:0]    load_y,
  output logic [X_W-1:0]    x,
  output logic [Y_W-1:0]    y,
  output logic [LIFE_W-1:0] life
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x    <= '0;
      y    <= '0;
      life <= '0;
    end else if (clear) begin
      x    <= '0;
      y    <= '0;
      life <= '0;
    end else if (load) begin
      x    <= X_W'(SPAWN_X);
      y    <= load_y;
      life <= LIFE_W'(LIFE_MAX);
    end else if (step && (life != '0)) begin
      // A particle that cannot drift further dies in place rather than wrapping.
      if (x >= X_W'(DRIFT)) begin
        x    <= x - X_W'(DRIFT);
        life <= life - LIFE_W'(1);
      end else begin
        life <= '0;
      end
    end
  end

endmodule

// File: rtl/player_trail_gen.sv
// Player trail generator: spawns fading particles behind the player once every
// SPAWN_INTERVAL frames into a ring of TRAIL_NUM slots.
//
//   state    | meaning
//   ST_CLEAR | gamemode start: trail wiped, pointer and spawn phase reset
//   ST_RUN   | in-game: on frame_tick drift/decay all slots, spawn on phase
//   ST_HOLD  | paused / game over: everything frozen, trail stays visible
module player_trail_gen
  import player_trail_gen_pkg::*;
#(
  parameter int TRAIL_NUM      = TRAIL_NUM_DEF,
  parameter int LIFE_MAX       = LIFE_MAX_DEF,
  parameter int SPAWN_INTERVAL = 2,
  parameter int DRIFT          = 4,
  parameter int PLAYER_X       = PLAYER_X_DEF,
  parameter int PLAYER_SIZE    = PLAYER_SIZE_DEF,
  parameter int TRAIL_SIZE     = TRAIL_SIZE_DEF
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               frame_tick,
  input  logic [1:0]                         gamemode,
  input  logic [Y_W-1:0]                     player_y,
  output logic [TRAIL_NUM-1:0][X_W-1:0]      trail_x,
  output logic [TRAIL_NUM-1:0][Y_W-1:0]      trail_y,
  output logic [TRAIL_NUM-1:0][LIFE_W-1:0]   trail_life
);

  localparam int PW      = (TRAIL_NUM > 1) ? $clog2(TRAIL_NUM) : 1;
  localparam int Y_OFF   = (PLAYER_SIZE - TRAIL_SIZE) / 2;
  localparam int SPAWN_X = PLAYER_X - TRAIL_SIZE;

  logic rst_meta, rst_sync_n;

  // Assert immediately, release two clocks later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_meta   <= 1'b0;
      rst_sync_n <= 1'b0;
    end else begin
      rst_meta   <= 1'b1;
      rst_sync_n <= rst_meta;
    end
  end

  trail_state_e   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic             clear, step, spawn;
  logic [Y_W-1:0]   y_spawn;

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state_q <= ST_CLEAR;
      cnt_q   <= CNT_W'(SPAWN_INTERVAL - 1);
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

  // Actions use the state being entered, so a tick on a mode change obeys the new mode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    clear   = 1'b0;
    step    = 1'b0;
    spawn   = 1'b0;

    case (gamemode)
      GM_START: state_d = ST_CLEAR;
      GM_PLAY:  state_d = ST_RUN;
      default:  state_d = ST_HOLD;
    endcase

    case (state_d)
      ST_CLEAR: begin
        clear = 1'b1;
        cnt_d = CNT_W'(SPAWN_INTERVAL - 1);
        ptr_d = '0;
      end
      ST_RUN: begin
        if (frame_tick) begin
          step = 1'b1;
          if (cnt_q == CNT_W'(SPAWN_INTERVAL - 1)) begin
            cnt_d = '0;
            spawn = 1'b1;
            ptr_d = (ptr_q == PW'(TRAIL_NUM - 1)) ? '0 : ptr_q + PW'(1);
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: ;
    endcase
  end

  assign y_spawn = spawn_y(player_y, Y_OFF);

  for (genvar i = 0; i < TRAIL_NUM; i++) begin : g_slot
    trail_slot #(
      .LIFE_MAX (LIFE_MAX),
      .DRIFT    (DRIFT),
      .SPAWN_X  (SPAWN_X)
    ) u_slot (
      .clk    (clk),
      .rst_n  (rst_sync_n),
      .clear  (clear),
      .step   (step),
      .load   (spawn && (ptr_q == PW'(i))),
      .load_y (y_spawn),
      .x      (trail_x[i]),
      .y      (trail_y[i]),
      .life   (trail_life[i])
    );
  end

endmodule
